// File: rtl/dir_ctrl_pkg.sv
// Shared encodings for the run/direction controller: FSM states, mode and
// direction values used on the counter interface.
package dir_ctrl_pkg;

    localparam logic [1:0] ST_STOP = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_REV  = 2'b10;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam logic SEL_UP = 1'b1;
    localparam logic SEL_DN = 1'b0;

endpackage

// File: rtl/dir_ctrl_btn_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A press first sampled at edge k yields a one-cycle pulse after edge k+2.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync_a;
    logic sync_b;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            prev   <= sync_b;
            pulse  <= sync_b & ~prev;
        end
    end

endmodule

// File: rtl/dir_ctrl.sv
// Run/direction controller for the up/down display counter: turns raw buttons
// and a speed select into a one-cycle count tick and a direction select.
module dir_ctrl
    import dir_ctrl_pkg::*;
#(
    parameter int DIV_BASE = 4,
    parameter int PRE_W    = 32,
    parameter int CNT_W    = 4
) (
    input  logic             dir_ctrl_clk,
    input  logic             dir_ctrl_rst,
    input  logic             dir_ctrl_btn_run,
    input  logic             dir_ctrl_btn_dir,
    input  logic [1:0]       dir_ctrl_speed,
    input  logic             dir_ctrl_mode,
    input  logic [CNT_W-1:0] dir_ctrl_q,
    output logic             dir_ctrl_en,
    output logic             dir_ctrl_sel,
    output logic             dir_ctrl_run,
    output logic [1:0]       dir_ctrl_state
);

    localparam logic [PRE_W-1:0] BASE  = PRE_W'(DIV_BASE);
    localparam logic [CNT_W-1:0] Q_MAX = {CNT_W{1'b1}};

    logic             run_ev;
    logic             dir_ev;
    logic [1:0]       state;
    logic             en;
    logic             sel;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] term;
    logic             tick;
    logic             at_limit;

    btn_edge u_run_edge (
        .clk   (dir_ctrl_clk),
        .rst   (dir_ctrl_rst),
        .btn   (dir_ctrl_btn_run),
        .pulse (run_ev)
    );

    btn_edge u_dir_edge (
        .clk   (dir_ctrl_clk),
        .rst   (dir_ctrl_rst),
        .btn   (dir_ctrl_btn_dir),
        .pulse (dir_ev)
    );

    // A >= compare means a speed drop mid-period fires at once instead of
    // waiting for the prescaler to wrap through the full register width.
    assign term     = (BASE << dir_ctrl_speed) - PRE_W'(1);
    assign tick     = (pre >= term);
    assign at_limit = (sel == SEL_UP) ? (dir_ctrl_q == Q_MAX)
                                      : (dir_ctrl_q == '0);

    always_ff @(posedge dir_ctrl_clk or posedge dir_ctrl_rst) begin
        if (dir_ctrl_rst) begin
            state <= ST_STOP;
            en    <= 1'b0;
            sel   <= SEL_UP;
            pre   <= '0;
        end else begin
            en <= 1'b0;
            case (state)
                ST_STOP: begin
                    pre <= '0;
                    if (run_ev) begin
                        state <= ST_RUN;
                    end else if (dir_ev) begin
                        sel <= ~sel;
                    end
                end
                ST_RUN: begin
                    if (run_ev) begin
                        state <= ST_STOP;
                        pre   <= '0;
                    end else if (dir_ev) begin
                        state <= ST_REV;
                        sel   <= ~sel;
                        pre   <= '0;
                    end else if (tick) begin
                        pre <= '0;
                        // Bounce swaps the tick for a reversal so the counter never passes a limit.
                        if (dir_ctrl_mode == MODE_BOUNCE && at_limit) begin
                            state <= ST_REV;
                            sel   <= ~sel;
                        end else begin
                            en <= 1'b1;
                        end
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end
                end
                ST_REV: begin
                    pre   <= '0;
                    state <= ST_RUN;
                end
                default: begin
                    pre   <= '0;
                    state <= ST_STOP;
                end
            endcase
        end
    end

    assign dir_ctrl_en    = en;
    assign dir_ctrl_sel   = sel;
    assign dir_ctrl_state = state;
    assign dir_ctrl_run   = (state == ST_RUN) || (state == ST_REV);

endmodule

// File: tb/tb_dir_ctrl.sv
// Bench for dir_ctrl: scenario tasks with inline checks, plus a monitor that
// matches every en pulse against a queue of expected tick cycles.
module tb_dir_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_run;
    logic        btn_dir;
    logic [1:0]  speed;
    logic        mode;
    logic [3:0]  q;
    logic        en;
    logic        sel;
    logic        run;
    logic [1:0]  state;

    logic [31:0] cyc;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] t0;
    int          total;
    int          bad;

    dir_ctrl #(.DIV_BASE(4), .PRE_W(32), .CNT_W(4)) dut (
        .dir_ctrl_clk     (clk),
        .dir_ctrl_rst     (rst),
        .dir_ctrl_btn_run (btn_run),
        .dir_ctrl_btn_dir (btn_dir),
        .dir_ctrl_speed   (speed),
        .dir_ctrl_mode    (mode),
        .dir_ctrl_q       (q),
        .dir_ctrl_en      (en),
        .dir_ctrl_sel     (sel),
        .dir_ctrl_run     (run),
        .dir_ctrl_state   (state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want summary first");
        $fatal(1);
    end

    // scoreboard: every en pulse must match the next expected tick cycle
    always @(negedge clk) begin
        if (rst === 1'b0 && en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL en_unexpected: en=1 at cycle %0d, want no tick", cyc);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    bad++;
                    $display("FAIL en_cycle: tick at cycle %0d, want %0d", cyc, e);
                end
            end
        end
    end

    // driver tasks (all called at a negedge)
    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic r, input logic d);
        btn_run = r;
        btn_dir = d;
        repeat (2) @(negedge clk);
        btn_run = 1'b0;
        btn_dir = 1'b0;
    endtask

    task automatic wait_until(input logic [31:0] c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s_missing_ticks: %0d ticks pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if ({en, sel, run, state} !== 5'b0_1_0_00) begin
            bad++;
            $display("FAIL reset_held: en/sel/run/state=%b, want 01000", {en, sel, run, state});
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({en, sel, run, state} !== 5'b0_1_0_00) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d en/sel/run/state=%b, want 01000", cyc, {en, sel, run, state});
            end
        end
    endtask

    task automatic test_run_stop();
        apply_reset();
        speed = 2'd0;
        mode  = 1'b0;
        t0 = cyc;
        exp_q.push_back(t0 + 8);
        exp_q.push_back(t0 + 12);
        exp_q.push_back(t0 + 16);
        press(1'b1, 1'b0);
        wait_until(t0 + 3);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL run_early: state=%b one edge early, want 00", state);
        end
        wait_until(t0 + 4);
        total++;
        if (state !== 2'b01 || run !== 1'b1) begin
            bad++;
            $display("FAIL run_enter: state=%b run=%b, want 01 1", state, run);
        end
        wait_until(t0 + 9);
        total++;
        if (sel !== 1'b1) begin
            bad++;
            $display("FAIL run_sel: sel=%b, want 1", sel);
        end
        wait_until(t0 + 16);
        press(1'b1, 1'b0);
        wait_until(t0 + 20);
        total++;
        if (state !== 2'b00 || run !== 1'b0 || en !== 1'b0) begin
            bad++;
            $display("FAIL run_stop: state=%b run=%b en=%b, want 00 0 0", state, run, en);
        end
        drain("run_stop");
    endtask

    task automatic test_speed_change();
        apply_reset();
        speed = 2'd2;
        mode  = 1'b0;
        t0 = cyc;
        exp_q.push_back(t0 + 20);
        exp_q.push_back(t0 + 36);
        exp_q.push_back(t0 + 47);
        exp_q.push_back(t0 + 51);
        exp_q.push_back(t0 + 55);
        press(1'b1, 1'b0);
        wait_until(t0 + 46);
        speed = 2'd0;
        wait_until(t0 + 47);
        total++;
        if (en !== 1'b1) begin
            bad++;
            $display("FAIL speed_drop_tick: en=%b right after speed drop, want 1", en);
        end
        wait_until(t0 + 52);
        press(1'b1, 1'b0);
        wait_until(t0 + 56);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL speed_stop: state=%b, want 00", state);
        end
        drain("speed");
    endtask

    task automatic test_dir_in_run();
        apply_reset();
        speed = 2'd0;
        mode  = 1'b0;
        t0 = cyc;
        exp_q.push_back(t0 + 8);
        exp_q.push_back(t0 + 12);
        exp_q.push_back(t0 + 16);
        exp_q.push_back(t0 + 22);
        exp_q.push_back(t0 + 26);
        exp_q.push_back(t0 + 30);
        press(1'b1, 1'b0);
        wait_until(t0 + 13);
        press(1'b0, 1'b1);
        wait_until(t0 + 16);
        total++;
        if (sel !== 1'b1) begin
            bad++;
            $display("FAIL dir_before: sel=%b, want 1", sel);
        end
        wait_until(t0 + 17);
        total++;
        if (state !== 2'b10 || en !== 1'b0 || sel !== 1'b0 || run !== 1'b1) begin
            bad++;
            $display("FAIL dir_rev: state=%b en=%b sel=%b run=%b, want 10 0 0 1", state, en, sel, run);
        end
        wait_until(t0 + 18);
        total++;
        if (state !== 2'b01 || sel !== 1'b0) begin
            bad++;
            $display("FAIL dir_back: state=%b sel=%b, want 01 0", state, sel);
        end
        wait_until(t0 + 27);
        press(1'b1, 1'b0);
        wait_until(t0 + 31);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL dir_stop: state=%b, want 00", state);
        end
        drain("dir");
    endtask

    task automatic test_bounce();
        apply_reset();
        speed = 2'd0;
        mode  = 1'b1;
        q     = 4'd0;
        t0 = cyc;
        exp_q.push_back(t0 + 8);
        exp_q.push_back(t0 + 12);
        exp_q.push_back(t0 + 21);
        exp_q.push_back(t0 + 30);
        exp_q.push_back(t0 + 34);
        exp_q.push_back(t0 + 38);
        press(1'b1, 1'b0);
        wait_until(t0 + 13);
        q = 4'd15;
        wait_until(t0 + 16);
        total++;
        if (state !== 2'b10 || sel !== 1'b0 || en !== 1'b0) begin
            bad++;
            $display("FAIL bounce_top: state=%b sel=%b en=%b, want 10 0 0", state, sel, en);
        end
        wait_until(t0 + 22);
        q = 4'd0;
        wait_until(t0 + 25);
        total++;
        if (state !== 2'b10 || sel !== 1'b1 || en !== 1'b0) begin
            bad++;
            $display("FAIL bounce_bottom: state=%b sel=%b en=%b, want 10 1 0", state, sel, en);
        end
        wait_until(t0 + 31);
        mode = 1'b0;
        q    = 4'd15;
        wait_until(t0 + 34);
        total++;
        if (en !== 1'b1 || state !== 2'b01) begin
            bad++;
            $display("FAIL wrap_at_max: en=%b state=%b, want 1 01", en, state);
        end
        wait_until(t0 + 35);
        press(1'b1, 1'b0);
        wait_until(t0 + 39);
        total++;
        if (state !== 2'b00) begin
            bad++;
            $display("FAIL bounce_stop: state=%b, want 00", state);
        end
        q = 4'd0;
        drain("bounce");
    endtask

    task automatic test_both_and_async_reset();
        apply_reset();
        speed = 2'd0;
        mode  = 1'b0;
        t0 = cyc;
        press(1'b0, 1'b1);
        wait_until(t0 + 4);
        total++;
        if (sel !== 1'b0 || state !== 2'b00) begin
            bad++;
            $display("FAIL stop_dir: sel=%b state=%b, want 0 00", sel, state);
        end
        wait_until(t0 + 6);
        press(1'b1, 1'b1);
        wait_until(t0 + 10);
        total++;
        if (state !== 2'b01 || sel !== 1'b0) begin
            bad++;
            $display("FAIL both_press: state=%b sel=%b, want 01 0", state, sel);
        end
        exp_q.push_back(t0 + 14);
        wait_until(t0 + 14);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({en, sel, run, state} !== 5'b0_1_0_00) begin
            bad++;
            $display("FAIL async_reset: en/sel/run/state=%b, want 01000", {en, sel, run, state});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain("async");
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        btn_run = 1'b0;
        btn_dir = 1'b0;
        speed   = 2'd0;
        mode    = 1'b0;
        q       = 4'd0;
        test_reset();
        test_run_stop();
        test_speed_change();
        test_dir_in_run();
        test_bounce();
        test_both_and_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
